alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational ALU_16 between two requesters (e.g. execute stage and address unit).
//   Round-robin arbitration, valid/ready handshakes on both sides, registered ALU operands.
//   Returns result plus z/v/n flags, tagged with requester id. One operation in flight at a time.
// PARAMETERS
//   WIDTH   16  operand/result width; must match the attached ALU
//   OP_W    3   ALU opcode width (`ALU_* codes)
// PORTS
//   clk        in   1        clock; all state updates on rising edge
//   rst        in   1        synchronous, active-high reset
//   req0_valid in   1        requester 0 has an operation
//   req0_op    in   OP_W     requester 0 opcode
//   req0_a     in   WIDTH    requester 0 operand A
//   req0_b     in   WIDTH    requester 0 operand B
//   req0_ready out  1        requester 0 accepted this cycle when req0_valid && req0_ready
//   req1_valid in   1        requester 1: same meaning as req0_*
//   req1_op    in   OP_W
//   req1_a     in   WIDTH
//   req1_b     in   WIDTH
//   req1_ready out  1
//   alu_op     out  OP_W     registered opcode driven to ALU
//   alu_a      out  WIDTH    registered operand A driven to ALU
//   alu_b      out  WIDTH    registered operand B driven to ALU
//   alu_out    in   WIDTH    ALU result (combinational from alu_op/a/b)
//   alu_z      in   1        ALU zero flag
//   alu_v      in   1        ALU overflow flag
//   alu_n      in   1        ALU negative flag
//   resp_valid out  1        response available
//   resp_ready in   1        consumer takes response when resp_valid && resp_ready
//   resp_id    out  1        requester that issued the op (0/1)
//   resp_data  out  WIDTH    captured alu_out
//   resp_z     out  1        captured alu_z
//   resp_v     out  1        captured alu_v
//   resp_n     out  1        captured alu_n
// BEHAVIOUR
//   - Reset: state=IDLE, last_grant=1 (so req0 wins first tie), alu_op/a/b=0,
//     resp_valid=0, resp_id=0, resp_data=0, resp_z/v/n=0. Reset wins over any handshake in that cycle.
//   - FSM: IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE: grant = only valid requester; if both valid, the one != last_grant.
//     reqX_ready=1 only for the granted requester, 0 otherwise; both ready=0 in EXEC/RESP.
//     On accept: latch op/a/b into alu_*, latch id, last_grant<=id, go EXEC.
//   - EXEC (1 cycle): ALU settles; at the edge capture alu_out/z/v/n into resp_*, go RESP.
//   - RESP: resp_valid=1; resp_* stable until resp_ready; on resp_valid&&resp_ready go IDLE.
//   - Latency: accept at edge N -> resp_valid high from cycle N+2; min 3 cycles per op.
//   - No accept while RESP is held; requesters keep valid/payload stable until ready.
//   - Requester dropping valid before grant: no effect, no op issued.
//   - alu_* hold last operands after completion (not cleared). Flags passed through unmodified.
// TESTING
//   - Reset: rst=1 for 2 cycles -> all outputs 0, req0_ready=req1_ready=0 with no valids.
//   - Single op: req0 `ALU_ADD a=1 b=1 -> resp_valid 2 cycles after accept, resp_id=0, data=16'h0002, z=v=n=0.
//   - Overflow: req1 `ALU_ADD a=16'h7FFF b=1 -> resp_id=1, data=16'h8000, n=1, v=1, z=0.
//   - Round-robin: both valid continuously, `ALU_ADD a=16'hFFFF b=1 -> ids 0,1,0,1; each data=0, z=1, n=0, v=0.
//   - Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable, both ready=0, no new accept; then completes.
//   - Reset mid-op: assert rst in EXEC -> next cycle IDLE, resp_valid=0, captured result discarded.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// One operation in flight: accept in IDLE, let the ALU settle in EXEC, hold the result in RESP.
module alu_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [OP_W-1:0]  alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_z,
  output logic             resp_v,
  output logic             resp_n
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q;
  logic   last_q;
  logic   id_q;
  logic   gnt_any;
  logic   gnt_id;

  // Grant only exists in IDLE; on a tie the requester that did not win last time goes.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_q;
      end else if (req0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_any && !gnt_id;
  assign req1_ready = gnt_any &&  gnt_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_z     <= 1'b0;
      resp_v     <= 1'b0;
      resp_n     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            alu_op  <= gnt_id ? req1_op : req0_op;
            alu_a   <= gnt_id ? req1_a  : req0_a;
            alu_b   <= gnt_id ? req1_b  : req0_b;
            id_q    <= gnt_id;
            last_q  <= gnt_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= alu_out;
          resp_z     <= alu_z;
          resp_v     <= alu_v;
          resp_n     <= alu_n;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed literal checks plus random traffic compared
// each cycle against a transaction-level model (timestamps and a pending-op record).
module tb_alu_share_arbiter;
  localparam int W = 16;
  localparam int OW = 3;
  localparam logic [2:0] OP_ADD = 3'd0, OP_XOR = 3'd4;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OW-1:0] req0_op, req1_op, alu_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, resp_data;
  logic alu_z, alu_v, alu_n, resp_valid, resp_ready, resp_id, resp_z, resp_v, resp_n;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .OP_W(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_z(resp_z), .resp_v(resp_v), .resp_n(resp_n)
  );

  // Reference ALU: returns {z, v, n, result}
  function automatic logic [W+2:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic v;
    v = 1'b0;
    case (op)
      3'd0: begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'd1: begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = a << 1;
      default: r = a >> 1;
    endcase
    return {(r == '0), v, r[W-1], r};
  endfunction

  always_comb begin
    logic [W+2:0] f;
    f = alu_fn(alu_op, alu_a, alu_b);
    {alu_z, alu_v, alu_n, alu_out} = f;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting, got no event expected one at %0t", name, $time);
  endtask

  // ---------------- behavioural model + compare ----------------
  bit model_on = 0;
  int cyc = 0;
  bit pend, exp_rv, last;
  int ready_at;
  logic p_id;
  logic [W+2:0] p_res;
  logic [OW-1:0] e_op;
  logic [W-1:0] e_a, e_b;
  logic e_id;
  logic [W+2:0] e_res;

  always @(negedge clk) begin
    logic g_any, g_id;
    g_any = !pend && (req0_valid || req1_valid);
    g_id  = (req0_valid && req1_valid) ? ~last : !req0_valid;
    if (model_on) begin
      chk("req0_ready", req0_ready, g_any && !g_id);
      chk("req1_ready", req1_ready, g_any && g_id);
      chk("resp_valid", resp_valid, exp_rv);
      chk("resp_id", resp_id, e_id);
      chk("resp_flags_data", {resp_z, resp_v, resp_n, resp_data}, e_res);
      chk("alu_regs", {alu_op, alu_a, alu_b}, {e_op, e_a, e_b});
    end
    if (rst) begin
      model_on = 1; pend = 0; exp_rv = 0; last = 1;
      e_op = '0; e_a = '0; e_b = '0; e_id = 0; e_res = '0;
    end else if (pend && cyc + 1 == ready_at) begin
      e_res = p_res; e_id = p_id; exp_rv = 1;
    end else if (exp_rv) begin
      if (resp_ready) begin exp_rv = 0; pend = 0; end
    end else if (g_any) begin
      pend = 1; p_id = g_id; last = g_id; ready_at = cyc + 2;
      e_op = g_id ? req1_op : req0_op;
      e_a  = g_id ? req1_a : req0_a;
      e_b  = g_id ? req1_b : req0_b;
      p_res = alu_fn(e_op, e_a, e_b);
    end
    cyc++;
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input logic id, output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin ok = 1; break; end
    end
    if (!ok) timeout("wait_ready");
  endtask

  task automatic single_op(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W+2:0] exp_res);
    bit ok;
    step();
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    resp_ready = 1;
    wait_ready(id, ok);
    step();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("lat_exec_no_resp", resp_valid, 1'b0);
    @(negedge clk);
    chk("lat_resp_valid", resp_valid, 1'b1);
    chk("lit_resp_id", resp_id, id);
    chk("lit_resp", {resp_z, resp_v, resp_n, resp_data}, exp_res);
  endtask

  initial begin
    bit ok;
    int k;
    logic [W+2:0] held;
    rst = 1; resp_ready = 0;
    req0_valid = 0; req1_valid = 0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_outputs", {resp_valid, resp_id, resp_z, resp_v, resp_n, resp_data, alu_op, alu_a, alu_b}, '0);
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    step();
    rst = 0;

    single_op(1'b0, OP_ADD, 16'h0001, 16'h0001, {3'b000, 16'h0002});
    single_op(1'b1, OP_ADD, 16'h7FFF, 16'h0001, {3'b011, 16'h8000});

    // round robin with both requesters continuously valid
    step();
    req0_valid = 1; req0_op = OP_ADD; req0_a = 16'hFFFF; req0_b = 16'h0001;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 16'hFFFF; req1_b = 16'h0001;
    resp_ready = 1;
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        chk("rr_id", resp_id, k % 2);
        chk("rr_resp", {resp_z, resp_v, resp_n, resp_data}, {3'b100, 16'h0000});
        k++;
      end
    end
    if (k < 4) timeout("round_robin");
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // backpressure: response held while another request waits
    resp_ready = 0;
    req0_valid = 1; req0_op = OP_XOR; req0_a = 16'h00FF; req0_b = 16'h0F0F;
    wait_ready(1'b0, ok);
    step();
    req0_valid = 0;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 16'h0003; req1_b = 16'h0004;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", resp_valid, 1'b1);
    held = {resp_z, resp_v, resp_n, resp_data};
    chk("bp_data", held, {3'b000, 16'h0FF0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stable", {resp_valid, resp_z, resp_v, resp_n, resp_data}, {1'b1, held});
      chk("bp_no_ready", {req0_ready, req1_ready}, 2'b00);
    end
    step();
    resp_ready = 1;
    wait_ready(1'b1, ok);
    step();
    req1_valid = 0;
    repeat (4) step();

    // reset while the operation is in EXEC
    req0_valid = 1; req0_op = OP_ADD; req0_a = 16'h1234; req0_b = 16'h1111;
    wait_ready(1'b0, ok);
    step();
    req0_valid = 0;
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_mid_valid", resp_valid, 1'b0);
    chk("rst_mid_data", {resp_id, resp_data, alu_a}, '0);
    repeat (2) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit a0, a1;
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      step();
      rst = ($urandom_range(0, 249) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid || a0 || $urandom_range(0, 9) == 0) begin
        req0_valid = $urandom_range(0, 1);
        req0_op = 3'($urandom_range(0, 7));
        req0_a = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
        req0_b = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
      end
      if (!req1_valid || a1 || $urandom_range(0, 9) == 0) begin
        req1_valid = $urandom_range(0, 1);
        req1_op = 3'($urandom_range(0, 7));
        req1_a = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
        req1_b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      end
    end
    step();
    rst = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
